// File: rtl/vram_arbiter_if.sv
// Bundle of every signal between the VRAM arbiter, its three requesters
// (pixel fetch, attribute fetch, CPU) and the single-port RAM primitive.
// slave  = arbiter side, master = requesters + RAM side.
interface vram_arbiter_if #(
  parameter int A_WIDTH = 16
);
  // CPU port
  logic               cpu_req;
  logic               cpu_we;
  logic [A_WIDTH-1:0] cpu_addr;
  logic [7:0]         cpu_din;
  logic               cpu_ack;
  logic               cpu_valid;
  logic [7:0]         cpu_dout;
  logic               cpu_wait_n;
  // Pixel fetch port
  logic               pix_req;
  logic [12:0]        pix_addr;
  logic               pix_ack;
  logic               pix_valid;
  logic [7:0]         pix_dout;
  // Attribute fetch port
  logic               attr_req;
  logic [12:0]        attr_addr;
  logic               attr_ack;
  logic               attr_valid;
  logic [7:0]         attr_dout;
  // RAM primitive port
  logic [A_WIDTH-1:0] ram_addr;
  logic               ram_we;
  logic [7:0]         ram_din;
  logic [7:0]         ram_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    output cpu_ack, cpu_valid, cpu_dout, cpu_wait_n,
    input  pix_req, pix_addr,
    output pix_ack, pix_valid, pix_dout,
    input  attr_req, attr_addr,
    output attr_ack, attr_valid, attr_dout,
    output ram_addr, ram_we, ram_din,
    input  ram_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cpu_ack, cpu_valid, cpu_dout, cpu_wait_n,
    output pix_req, pix_addr,
    input  pix_ack, pix_valid, pix_dout,
    output attr_req, attr_addr,
    input  attr_ack, attr_valid, attr_dout,
    input  ram_addr, ram_we, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/vram_arbiter.sv
// Time-shares one single-port synchronous 8-bit RAM between pixel fetch,
// attribute fetch and the CPU. Video wins by default; a saturating
// starvation counter forces a CPU slot after MAX_CPU_WAIT lost cycles.
// One grant per clock; reads return through a 2-stage tag pipeline.
module vram_arbiter #(
  parameter int A_WIDTH      = 16,
  parameter int MAX_CPU_WAIT = 6
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {TAG_NONE, TAG_PIX, TAG_ATTR, TAG_CPU} tag_e;

  localparam int            CW   = $clog2(MAX_CPU_WAIT + 1);
  localparam logic [CW-1:0] MAXW = CW'(MAX_CPU_WAIT);

  tag_e          grant;
  tag_e          tag_s1;     // read tag for the ack cycle (address on RAM)
  tag_e          tag_s2;     // read tag for the cycle ram_dout is valid
  logic [CW-1:0] starve_cnt;
  logic          cpu_done;
  logic          cpu_pend;

  // Pick this edge's winner: forced CPU slot, else pix > attr > cpu.
  always_comb begin
    grant = TAG_NONE;
    if (bus.cpu_req && starve_cnt == MAXW) grant = TAG_CPU;
    else if (bus.pix_req)                  grant = TAG_PIX;
    else if (bus.attr_req)                 grant = TAG_ATTR;
    else if (bus.cpu_req)                  grant = TAG_CPU;
  end

  // Grant register, RAM command, read tag pipeline, data capture, starvation.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.cpu_ack    <= 1'b0;
      bus.pix_ack    <= 1'b0;
      bus.attr_ack   <= 1'b0;
      bus.cpu_valid  <= 1'b0;
      bus.pix_valid  <= 1'b0;
      bus.attr_valid <= 1'b0;
      bus.cpu_dout   <= '0;
      bus.pix_dout   <= '0;
      bus.attr_dout  <= '0;
      bus.ram_addr   <= '0;
      bus.ram_we     <= 1'b0;
      bus.ram_din    <= '0;
      tag_s1         <= TAG_NONE;
      tag_s2         <= TAG_NONE;
      starve_cnt     <= '0;
    end else begin
      bus.pix_ack  <= (grant == TAG_PIX);
      bus.attr_ack <= (grant == TAG_ATTR);
      bus.cpu_ack  <= (grant == TAG_CPU);

      bus.ram_we <= 1'b0;
      case (grant)
        TAG_PIX:  bus.ram_addr <= A_WIDTH'(bus.pix_addr);
        TAG_ATTR: bus.ram_addr <= A_WIDTH'(bus.attr_addr);
        TAG_CPU: begin
          bus.ram_addr <= bus.cpu_addr;
          bus.ram_we   <= bus.cpu_we;
          bus.ram_din  <= bus.cpu_din;
        end
        default: ;
      endcase

      // CPU writes finish at the ack, so they never enter the read pipe.
      tag_s1 <= (grant == TAG_CPU && bus.cpu_we) ? TAG_NONE : grant;
      tag_s2 <= tag_s1;

      bus.pix_valid  <= (tag_s2 == TAG_PIX);
      bus.attr_valid <= (tag_s2 == TAG_ATTR);
      bus.cpu_valid  <= (tag_s2 == TAG_CPU);
      if (tag_s2 == TAG_PIX)  bus.pix_dout  <= bus.ram_dout;
      if (tag_s2 == TAG_ATTR) bus.attr_dout <= bus.ram_dout;
      if (tag_s2 == TAG_CPU)  bus.cpu_dout  <= bus.ram_dout;

      if (grant == TAG_CPU || !bus.cpu_req) starve_cnt <= '0;
      else if (starve_cnt != MAXW)          starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // A CPU read stays outstanding until its valid; a write completes at its ack.
  assign cpu_pend       = (tag_s1 == TAG_CPU) || (tag_s2 == TAG_CPU);
  assign cpu_done       = bus.cpu_valid || (bus.cpu_ack && bus.ram_we);
  assign bus.cpu_wait_n = !((bus.cpu_req || cpu_pend) && !cpu_done);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_vram_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Preload port into the RAM model, used only during reset.
  logic        pl_we;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;
  logic [7:0]  mem [0:65535];

  vram_arbiter_if #(.A_WIDTH(16)) bus ();

  vram_arbiter #(.A_WIDTH(16), .MAX_CPU_WAIT(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single-port read-first RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_we = 1'b0;
  endtask

  logic [7:0] exp_pix [4];

  initial begin
    reset = 1'b1;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.pix_req = 1'b0; bus.pix_addr = '0;
    bus.attr_req = 1'b0; bus.attr_addr = '0;
    exp_pix[0] = 8'h11; exp_pix[1] = 8'hB1; exp_pix[2] = 8'hB2; exp_pix[3] = 8'hB3;
    repeat (2) step();
    preload(16'h0000, 8'h11);
    preload(16'h0001, 8'hB1);
    preload(16'h0002, 8'hB2);
    preload(16'h0003, 8'hB3);
    preload(16'h1800, 8'h22);
    preload(16'h2000, 8'h33);
    preload(16'h1234, 8'hA5);
    step();
    reset = 1'b0;

    // Reset state
    #1;
    chk("rst_acks",   {bus.pix_ack, bus.attr_ack, bus.cpu_ack}, 3'b000);
    chk("rst_valids", {bus.pix_valid, bus.attr_valid, bus.cpu_valid}, 3'b000);
    chk("rst_ram_we", bus.ram_we, 1'b0);
    chk("rst_ram_addr", bus.ram_addr, 16'h0000);
    chk("rst_ram_din",  bus.ram_din, 8'h00);
    chk("rst_wait_n", bus.cpu_wait_n, 1'b1);
    chk("rst_douts",  {bus.pix_dout, bus.attr_dout, bus.cpu_dout}, 24'h0);

    // Single CPU read of 0x1234
    step();                                   // cycle 0
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
    #1 chk("rd_c0_wait_n", bus.cpu_wait_n, 1'b0);
    step();                                   // cycle 1
    chk("rd_c1_ack", bus.cpu_ack, 1'b1);
    chk("rd_c1_addr", {bus.ram_we, bus.ram_addr}, {1'b0, 16'h1234});
    bus.cpu_req = 1'b0;
    #1 chk("rd_c1_wait_n", bus.cpu_wait_n, 1'b0);
    step();                                   // cycle 2
    chk("rd_c2_ack_valid", {bus.cpu_ack, bus.cpu_valid}, 2'b00);
    chk("rd_c2_wait_n", bus.cpu_wait_n, 1'b0);
    step();                                   // cycle 3
    chk("rd_c3_valid", bus.cpu_valid, 1'b1);
    chk("rd_c3_dout", bus.cpu_dout, 8'hA5);
    chk("rd_c3_wait_n", bus.cpu_wait_n, 1'b1);
    step();                                   // cycle 4
    chk("rd_c4_valid", bus.cpu_valid, 1'b0);
    chk("rd_c4_dout_held", bus.cpu_dout, 8'hA5);

    // CPU write 0x5A to 0x0010, then read it back
    step();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_din = 8'h5A;
    #1 chk("wr_c0_wait_n", bus.cpu_wait_n, 1'b0);
    step();
    chk("wr_c1_ack", bus.cpu_ack, 1'b1);
    chk("wr_c1_ram", {bus.ram_we, bus.ram_addr, bus.ram_din}, {1'b1, 16'h0010, 8'h5A});
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    #1 chk("wr_c1_wait_n", bus.cpu_wait_n, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk($sformatf("wr_c%0d_no_valid", c), bus.cpu_valid, 1'b0);
    end
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
    step();
    chk("wrd_ack", bus.cpu_ack, 1'b1);
    bus.cpu_req = 1'b0;
    step();
    step();
    chk("wrd_valid", bus.cpu_valid, 1'b1);
    chk("wrd_dout", bus.cpu_dout, 8'h5A);

    // Simultaneous pix / attr / cpu requests
    step();                                   // cycle 0
    bus.pix_req = 1'b1;  bus.pix_addr = 13'h0000;
    bus.attr_req = 1'b1; bus.attr_addr = 13'h1800;
    bus.cpu_req = 1'b1;  bus.cpu_we = 1'b0; bus.cpu_addr = 16'h2000;
    step();                                   // cycle 1
    chk("sim_c1_acks", {bus.pix_ack, bus.attr_ack, bus.cpu_ack}, 3'b100);
    chk("sim_c1_addr", bus.ram_addr, 16'h0000);
    bus.pix_req = 1'b0;
    step();                                   // cycle 2
    chk("sim_c2_acks", {bus.pix_ack, bus.attr_ack, bus.cpu_ack}, 3'b010);
    chk("sim_c2_addr", bus.ram_addr, 16'h1800);
    bus.attr_req = 1'b0;
    step();                                   // cycle 3
    chk("sim_c3_acks", {bus.pix_ack, bus.attr_ack, bus.cpu_ack}, 3'b001);
    chk("sim_c3_addr", bus.ram_addr, 16'h2000);
    chk("sim_c3_valids", {bus.pix_valid, bus.attr_valid, bus.cpu_valid}, 3'b100);
    chk("sim_c3_pix", bus.pix_dout, 8'h11);
    bus.cpu_req = 1'b0;
    step();                                   // cycle 4
    chk("sim_c4_valids", {bus.pix_valid, bus.attr_valid, bus.cpu_valid}, 3'b010);
    chk("sim_c4_attr", bus.attr_dout, 8'h22);
    step();                                   // cycle 5
    chk("sim_c5_valids", {bus.pix_valid, bus.attr_valid, bus.cpu_valid}, 3'b001);
    chk("sim_c5_cpu", bus.cpu_dout, 8'h33);
    repeat (2) step();

    // Starvation guard: pix held, CPU forced in after 6 lost cycles
    bus.pix_req = 1'b1; bus.pix_addr = 13'h0000;  // cycle 0
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("stv_c%0d_acks", c), {bus.pix_ack, bus.cpu_ack}, 2'b10);
    end
    step();                                   // cycle 7
    chk("stv_c7_acks", {bus.pix_ack, bus.cpu_ack}, 2'b01);
    chk("stv_c7_addr", bus.ram_addr, 16'h1234);
    bus.cpu_req = 1'b0;
    step();                                   // cycle 8
    chk("stv_c8_acks", {bus.pix_ack, bus.cpu_ack}, 2'b10);
    bus.pix_req = 1'b0;
    step();                                   // cycle 9
    chk("stv_c9_cpu_valid", {bus.cpu_valid, bus.cpu_dout}, {1'b1, 8'hA5});
    repeat (3) step();

    // Pipelined video reads 0x0000..0x0003
    bus.pix_req = 1'b1; bus.pix_addr = 13'h0000;  // cycle 0
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 4) begin
        chk($sformatf("pipe_c%0d_ack", c), bus.pix_ack, 1'b1);
        chk($sformatf("pipe_c%0d_addr", c), bus.ram_addr, 16'(c - 1));
        if (c < 4) bus.pix_addr = 13'(c);
        else       bus.pix_req  = 1'b0;
      end
      if (c >= 3) begin
        chk($sformatf("pipe_c%0d_valid", c), bus.pix_valid, 1'b1);
        chk($sformatf("pipe_c%0d_dout", c), bus.pix_dout, exp_pix[c-3]);
      end
    end
    step();
    chk("pipe_c7_valid", bus.pix_valid, 1'b0);
    repeat (2) step();

    // Reset during an in-flight pixel read
    bus.pix_req = 1'b1; bus.pix_addr = 13'h0001;  // cycle 0
    step();                                   // cycle 1
    chk("rmid_c1_ack", bus.pix_ack, 1'b1);
    bus.pix_req = 1'b0;
    step();                                   // cycle 2
    reset = 1'b1;
    step();                                   // cycle 3
    reset = 1'b0;
    chk("rmid_c3_valids", {bus.pix_valid, bus.attr_valid, bus.cpu_valid}, 3'b000);
    chk("rmid_c3_acks", {bus.pix_ack, bus.attr_ack, bus.cpu_ack}, 3'b000);
    chk("rmid_c3_douts", {bus.pix_dout, bus.attr_dout, bus.cpu_dout}, 24'h0);
    chk("rmid_c3_ram", {bus.ram_we, bus.ram_addr, bus.ram_din}, 25'h0);
    chk("rmid_c3_wait_n", bus.cpu_wait_n, 1'b1);
    step();                                   // cycle 4
    chk("rmid_c4_no_valid", bus.pix_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
